// File: rtl/buf_kernel_pkg.sv
// Shared constants and loader state encoding for the kernel buffer path.
// Used by buf_kernel_loader and loader_chksum (LOADER_CHKSUM_EN build).
package buf_kernel_pkg;
  localparam int DATALEN   = 64;
  localparam int KERNWORDS = 512;
  localparam int SELWORDS  = 128;
  localparam int REPLLEN   = 4;
  localparam int CNTLEN    = 10;
  localparam int INDXLEN   = $clog2(KERNWORDS);
  localparam int PARAKRN   = 8;
  localparam int SELBITS   = PARAKRN * (REPLLEN + 1);

  typedef enum logic [2:0] {IDLE, KERN, SEL, CHK, FIN} ld_state_e;

  // Select words carry only PARAKRN packed fields; upper bits are zeroed.
  function automatic logic [DATALEN-1:0] sel_mask(input logic [DATALEN-1:0] w);
    sel_mask = '0;
    sel_mask[SELBITS-1:0] = w[SELBITS-1:0];
  endfunction
endpackage

// File: rtl/loader_chksum.sv
// XOR accumulator over accepted set words plus trailer compare.
// Instantiated by buf_kernel_loader only when LOADER_CHKSUM_EN is defined.
module loader_chksum
  import buf_kernel_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               acc_en_i,
  input  logic               cmp_en_i,
  input  logic [DATALEN-1:0] data_i,
  output logic               chk_err_o
);
  logic [DATALEN-1:0] acc_q, acc_d;
  logic               err_q, err_d;

  always_comb begin
    acc_d = acc_q;
    err_d = err_q;
    if (clr_i) begin
      acc_d = '0;
      err_d = 1'b0;
    end else begin
      if (acc_en_i) acc_d = acc_q ^ data_i;
      if (cmp_en_i && (data_i != acc_q)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end

  assign chk_err_o = err_q;
endmodule

// File: rtl/buf_kernel_loader.sv
// Frames one kernel set (KERNWORDS kernel words, SELWORDS select words) from a
// valid/ready stream into registered write strobes. Optional LOADER_CHKSUM_EN adds an XOR trailer check.
module buf_kernel_loader
  import buf_kernel_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               s_valid,
  input  logic [DATALEN-1:0] s_data,
  input  logic               s_last,
  output logic               s_ready,
  output logic               invalid,
  output logic               iskern,
  output logic               issel,
  output logic [DATALEN-1:0] indata,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef LOADER_CHKSUM_EN
  ,
  output logic               chk_err
`endif
);
  ld_state_e          state_q, state_d;
  logic [CNTLEN-1:0]  cnt_q, cnt_d;
  logic               iskern_q, iskern_d;
  logic               issel_q, issel_d;
  logic [DATALEN-1:0] indata_q, indata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               xfer, last_kern, last_sel;

  // Ready depends only on registered state, never on s_valid.
  assign s_ready   = (state_q == KERN) || (state_q == SEL) || (state_q == CHK);
  assign xfer      = s_valid & s_ready;
  assign last_kern = (cnt_q == CNTLEN'(KERNWORDS - 1));
  assign last_sel  = (cnt_q == CNTLEN'(SELWORDS - 1));

`ifdef LOADER_CHKSUM_EN
  logic ck_clr, ck_acc, ck_cmp;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    iskern_d = 1'b0;
    issel_d  = 1'b0;
    indata_d = indata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
`ifdef LOADER_CHKSUM_EN
    ck_clr = 1'b0;
    ck_acc = 1'b0;
    ck_cmp = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = KERN;
          cnt_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef LOADER_CHKSUM_EN
          ck_clr  = 1'b1;
`endif
        end
      end
      KERN: begin
        if (xfer) begin
          if (s_last) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            iskern_d = 1'b1;
            indata_d = s_data;
`ifdef LOADER_CHKSUM_EN
            ck_acc   = 1'b1;
`endif
            if (last_kern) begin
              state_d = SEL;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNTLEN'(1);
            end
          end
        end
      end
      SEL: begin
        if (xfer) begin
`ifdef LOADER_CHKSUM_EN
          // The trailer carries s_last here, so any s_last in SEL is early.
          if (s_last) begin
`else
          if (s_last && !last_sel) begin
`endif
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            issel_d  = 1'b1;
            indata_d = sel_mask(s_data);
`ifdef LOADER_CHKSUM_EN
            ck_acc   = 1'b1;
`endif
            if (last_sel) begin
              cnt_d = '0;
`ifdef LOADER_CHKSUM_EN
              state_d = CHK;
`else
              state_d = FIN;
              if (!s_last) err_d = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + CNTLEN'(1);
            end
          end
        end
      end
      CHK: begin
        if (xfer) begin
          state_d = FIN;
          if (!s_last) err_d = 1'b1;
`ifdef LOADER_CHKSUM_EN
          ck_cmp  = 1'b1;
`endif
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      iskern_q <= 1'b0;
      issel_q  <= 1'b0;
      indata_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      iskern_q <= iskern_d;
      issel_q  <= issel_d;
      indata_q <= indata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef LOADER_CHKSUM_EN
  loader_chksum u_chksum (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (ck_clr),
    .acc_en_i  (ck_acc),
    .cmp_en_i  (ck_cmp),
    .data_i    (s_data),
    .chk_err_o (chk_err)
  );
`endif

  assign iskern  = iskern_q;
  assign issel   = issel_q;
  assign invalid = iskern_q | issel_q;
  assign indata  = indata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
endmodule
